// File: rtl/fsk_mod_if.sv
// Transmit-side bundle for the FSK modulator: byte handshake in, symbol/carrier status out.
// The master drives the byte stream and the slave is the modulator.
interface fsk_mod_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 busy;
    logic                 sym_out;
    logic                 fsk_out;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  busy,
        input  sym_out,
        input  fsk_out
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output busy,
        output sym_out,
        output fsk_out
    );
endinterface

// File: rtl/fsk_mod.sv
// Binary FSK modulator: frames a word UART-style (start, LSB-first data, stop) onto a square-wave carrier.
// Latency: first start-symbol cycle follows the accept edge; a frame lasts (DATA_BITS+2)*BAUD_DIV cycles.
// Backpressure: tx_ready is low from accept through the last stop cycle; tx_valid is ignored meanwhile.
module fsk_mod #(
    parameter int BAUD_DIV  = 64,
    parameter int HALF0     = 8,
    parameter int HALF1     = 4,
    parameter int DATA_BITS = 8
) (
    input  logic      clk,
    input  logic      rst,
    fsk_mod_if.slave  bus
);
    localparam int HMAX = (HALF0 > HALF1) ? HALF0 : HALF1;
    localparam int BCW  = $clog2(BAUD_DIV);
    localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;
    localparam int BW   = $clog2(DATA_BITS + 1);

    localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
    localparam logic [HW-1:0]  H0_LAST   = HW'(HALF0 - 1);
    localparam logic [HW-1:0]  H1_LAST   = HW'(HALF1 - 1);
    localparam logic [BW-1:0]  BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_q;
    state_t               state_d;
    logic [BCW-1:0]       baud_cnt;
    logic [HW-1:0]        half_cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 tx_ready_q;
    logic                 busy_q;
    logic                 fsk_q;

    logic accept;
    logic sym_end;
    logic sym;
    logic toggle;

    always_comb begin
        state_d = state_q;
        sym     = 1'b1;
        accept  = bus.tx_valid && tx_ready_q;
        sym_end = (state_q != IDLE) && (baud_cnt == BAUD_LAST);
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = START;
            end
            START: begin
                sym = 1'b0;
                if (sym_end) state_d = DATA;
            end
            DATA: begin
                sym = shreg[0];
                if (sym_end && (bit_idx == BIT_LAST)) state_d = STOP;
            end
            STOP: begin
                if (sym_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Toggle decision uses the half-period of the symbol currently on the line.
        toggle = (half_cnt >= (sym ? H1_LAST : H0_LAST));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_cnt   <= '0;
            half_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            fsk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_ready_q <= (state_d == IDLE);
            busy_q     <= (state_d != IDLE);

            if (accept)
                shreg <= bus.tx_data;
            else if ((state_q == DATA) && sym_end)
                shreg <= shreg >> 1;

            if ((state_q == IDLE) || sym_end)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;

            if (state_q == START)
                bit_idx <= '0;
            else if ((state_q == DATA) && sym_end)
                bit_idx <= bit_idx + 1'b1;

            // Phase restarts at each symbol, but the output level is carried across.
            fsk_q <= fsk_q ^ toggle;
            if (accept || sym_end || toggle)
                half_cnt <= '0;
            else
                half_cnt <= half_cnt + 1'b1;
        end
    end

    assign bus.tx_ready = tx_ready_q;
    assign bus.busy     = busy_q;
    assign bus.sym_out  = sym;
    assign bus.fsk_out  = fsk_q;
endmodule
